row_vec_fetch: RTL and testbench

- Read-side fetch engine directly upstream of the solver datapath; drives both ports of the dual-port 32-bit SRAM macro.
- Per command, streams LEN element pairs: the matrix row from port A (ROW_BASE+k) and the vector from port B (VEC_BASE+k).
- Hides the SRAM's one-cycle registered read latency and absorbs consumer backpressure with a 3-entry output FIFO.
- Sustains one pair per cycle when O_READY stays high.

---
 rtl/row_vec_fetch.sv | 160 ++++++++++++++++
 tb/tb_row_vec_fetch.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_vec_fetch.sv
// Row/vector fetch engine: streams LEN (matrix, vector) word pairs from a dual-port
// SRAM into a 3-entry output FIFO with one pair per cycle at full rate.
module row_vec_fetch #(
  parameter int BITS       = 32,
  parameter int ADDR_WIDTH = 15,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] ROW_BASE,
  input  logic [ADDR_WIDTH-1:0] VEC_BASE,
  input  logic [LEN_WIDTH-1:0]  LEN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  CENA,
  output logic                  WENA,
  output logic [ADDR_WIDTH-1:0] AA,
  output logic [BITS-1:0]       DA,
  output logic                  CENB,
  output logic                  WENB,
  output logic [ADDR_WIDTH-1:0] AB,
  output logic [BITS-1:0]       DB,
  input  logic [BITS-1:0]       QA,
  input  logic [BITS-1:0]       QB,
  output logic                  O_VALID,
  input  logic                  O_READY,
  output logic [BITS-1:0]       O_A,
  output logic [BITS-1:0]       O_B,
  output logic                  O_LAST
);

  localparam int DEPTH = 3;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                state;
  logic                  cen;
  logic [ADDR_WIDTH-1:0] row_ptr;
  logic [ADDR_WIDTH-1:0] vec_ptr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  iss_last;

  logic                  cap_vld;
  logic                  cap_last;
  logic [1:0]            occ;
  logic [BITS-1:0]       fifo_a [DEPTH];
  logic [BITS-1:0]       fifo_b [DEPTH];
  logic                  fifo_l [DEPTH];

  logic                  pop;
  logic                  push;
  logic                  credit_ok;
  logic [1:0]            wr_idx;

  // cap_vld marks SRAM Q holding a word not yet in the FIFO; with CEN high the SRAM
  // keeps Q, so it acts as a fourth slot and the credit ignores the read issued this cycle.
  assign credit_ok = (3'(occ) + 3'(cap_vld)) < 3'(DEPTH);
  assign pop       = O_VALID & O_READY;
  assign push      = cap_vld & ((occ != 2'(DEPTH)) | pop);
  assign wr_idx    = occ - 2'(pop);

  assign CENA    = cen;
  assign CENB    = cen;
  assign WENA    = 1'b1;
  assign WENB    = 1'b1;
  assign DA      = '0;
  assign DB      = '0;
  assign O_VALID = (occ != 2'd0);
  assign O_A     = fifo_a[0];
  assign O_B     = fifo_b[0];
  assign O_LAST  = fifo_l[0];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      cen       <= 1'b1;
      AA        <= '0;
      AB        <= '0;
      row_ptr   <= '0;
      vec_ptr   <= '0;
      remaining <= '0;
      iss_last  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      cen  <= 1'b1;
      case (state)
        IDLE: begin
          if (START) begin
            if (LEN != '0) begin
              state     <= FETCH;
              BUSY      <= 1'b1;
              cen       <= 1'b0;
              AA        <= ROW_BASE;
              AB        <= VEC_BASE;
              row_ptr   <= ROW_BASE + ADDR_WIDTH'(1);
              vec_ptr   <= VEC_BASE + ADDR_WIDTH'(1);
              remaining <= LEN - LEN_WIDTH'(1);
              iss_last  <= (LEN == LEN_WIDTH'(1));
            end else begin
              DONE <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (remaining == '0) begin
            state <= DRAIN;
          end else if (credit_ok) begin
            cen       <= 1'b0;
            AA        <= row_ptr;
            AB        <= vec_ptr;
            row_ptr   <= row_ptr + ADDR_WIDTH'(1);
            vec_ptr   <= vec_ptr + ADDR_WIDTH'(1);
            remaining <= remaining - LEN_WIDTH'(1);
            iss_last  <= (remaining == LEN_WIDTH'(1));
          end
        end
        DRAIN: begin
          if (pop && O_LAST) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cap_vld  <= 1'b0;
      cap_last <= 1'b0;
      occ      <= '0;
      fifo_a   <= '{default: '0};
      fifo_b   <= '{default: '0};
      fifo_l   <= '{default: 1'b0};
    end else begin
      cap_vld <= ~cen | (cap_vld & ~push);
      if (!cen) cap_last <= iss_last;
      if (pop) begin
        fifo_a[0] <= fifo_a[1];
        fifo_a[1] <= fifo_a[2];
        fifo_b[0] <= fifo_b[1];
        fifo_b[1] <= fifo_b[2];
        fifo_l[0] <= fifo_l[1];
        fifo_l[1] <= fifo_l[2];
      end
      if (push) begin
        fifo_a[wr_idx] <= QA;
        fifo_b[wr_idx] <= QB;
        fifo_l[wr_idx] <= cap_last;
      end
      occ <= occ + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_row_vec_fetch.sv
// Scoreboard bench for row_vec_fetch: behavioural dual-port SRAM, expected pairs and
// addresses queued at command issue, independent monitors pop and compare.
module tb_row_vec_fetch;

  localparam int BITS = 32;
  localparam int AW   = 15;
  localparam int LW   = 16;

  logic            CLK = 1'b0;
  logic            RSTN = 1'b0;
  logic            START = 1'b0;
  logic [AW-1:0]   ROW_BASE = '0;
  logic [AW-1:0]   VEC_BASE = '0;
  logic [LW-1:0]   LEN = '0;
  logic            BUSY, DONE, CENA, WENA, CENB, WENB;
  logic [AW-1:0]   AA, AB;
  logic [BITS-1:0] DA, DB;
  logic [BITS-1:0] QA = '0;
  logic [BITS-1:0] QB = '0;
  logic            O_VALID;
  logic            O_READY = 1'b1;
  logic [BITS-1:0] O_A, O_B;
  logic            O_LAST;

  row_vec_fetch #(.BITS(BITS), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .ROW_BASE(ROW_BASE), .VEC_BASE(VEC_BASE),
    .LEN(LEN), .BUSY(BUSY), .DONE(DONE), .CENA(CENA), .WENA(WENA), .AA(AA), .DA(DA),
    .CENB(CENB), .WENB(WENB), .AB(AB), .DB(DB), .QA(QA), .QB(QB), .O_VALID(O_VALID),
    .O_READY(O_READY), .O_A(O_A), .O_B(O_B), .O_LAST(O_LAST)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [BITS-1:0] mem_a [0:32767];
  logic [BITS-1:0] mem_b [0:32767];
  always @(posedge CLK) begin
    if (!CENA) QA <= mem_a[AA];
    if (!CENB) QB <= mem_b[AB];
  end

  typedef struct {
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic            last;
    int              cyc;
  } pair_t;
  typedef struct {
    logic [AW-1:0] aa;
    logic [AW-1:0] ab;
  } addr_t;

  pair_t exp_q[$];
  addr_t addr_q[$];
  int n_vec = 0;
  int n_err = 0;
  int n_pop = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // pair monitor: pops the scoreboard on each transfer, checks hold while stalled
  bit              held = 1'b0;
  logic [BITS-1:0] h_a, h_b;
  logic            h_l;
  always @(negedge CLK) begin
    pair_t e;
    if (!RSTN) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("stall_valid", O_VALID, 1'b1);
        check("stall_a", O_A, h_a);
        check("stall_b", O_B, h_b);
        check("stall_last", O_LAST, h_l);
      end
      if (O_VALID && O_READY) begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pair: got A=%0h B=%0h at cycle %0d, required none", O_A, O_B, cyc);
        end else begin
          e = exp_q.pop_front();
          check("pair_a", O_A, e.a);
          check("pair_b", O_B, e.b);
          check("pair_last", O_LAST, e.last);
          if (e.cyc >= 0) check("pair_cycle", cyc, e.cyc);
          n_pop++;
        end
      end else if (O_VALID) begin
        held = 1'b1;
        h_a  = O_A;
        h_b  = O_B;
        h_l  = O_LAST;
      end else begin
        held = 1'b0;
      end
    end
  end

  // address monitor: every enabled SRAM cycle must match the next expected read
  always @(negedge CLK) begin
    addr_t a;
    if (RSTN) begin
      if (CENA !== CENB) check("cen_pair", CENB, CENA);
      if (!CENA) begin
        if (addr_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_issue: got AA=%0d AB=%0d at cycle %0d, required no access", AA, AB, cyc);
        end else begin
          a = addr_q.pop_front();
          check("addr_a", AA, a.aa);
          check("addr_b", AB, a.ab);
          check("wen_ab", {WENA, WENB}, 2'b11);
          check("din_ab", {DA, DB}, 64'h0);
        end
      end
    end
  end

  task automatic do_cmd(input logic [AW-1:0] row, input logic [AW-1:0] vec, input int len,
                        input bit timed, output int t0);
    pair_t e;
    addr_t a;
    logic [AW-1:0] ra, va;
    @(posedge CLK); #1;
    START = 1'b1;
    ROW_BASE = row;
    VEC_BASE = vec;
    LEN = LW'(len);
    t0 = cyc;
    for (int k = 0; k < len; k++) begin
      ra = row + AW'(k);
      va = vec + AW'(k);
      a.aa = ra;
      a.ab = va;
      addr_q.push_back(a);
      e.a = mem_a[ra];
      e.b = mem_b[va];
      e.last = (k == len - 1);
      e.cyc = timed ? t0 + 3 + k : -1;
      exp_q.push_back(e);
    end
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic run_until_done(input bit bp, output int dcyc);
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    dcyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (DONE) begin
        dcyc = cyc;
        break;
      end
      @(posedge CLK); #1;
      if (bp) O_READY = pat[i % 6];
    end
    O_READY = 1'b1;
    if (dcyc < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no DONE within 200 cycles, required DONE");
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, BUSY, 1'b0);
    check({tag, "_done"}, DONE, 1'b0);
    check({tag, "_cena"}, CENA, 1'b1);
    check({tag, "_cenb"}, CENB, 1'b1);
    check({tag, "_aa"}, AA, '0);
    check({tag, "_ab"}, AB, '0);
    check({tag, "_ovalid"}, O_VALID, 1'b0);
    check({tag, "_olast"}, O_LAST, 1'b0);
    check({tag, "_oa"}, O_A, '0);
    check({tag, "_ob"}, O_B, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, d, p0;
    for (int i = 0; i < 32768; i++) begin
      mem_a[i] = 32'hA000_0000 | i;
      mem_b[i] = 32'hB000_0000 | i;
    end
    for (int k = 0; k < 4; k++) begin
      mem_a[100 + k] = k;
      mem_b[200 + k] = 10 * k;
    end

    repeat (3) @(posedge CLK);
    #1;
    check_reset_state("rst");
    check("rst_wen", {WENA, WENB}, 2'b11);
    check("rst_din", {DA, DB}, 64'h0);
    RSTN = 1'b1;

    // basic stream: pairs (0,0)(1,10)(2,20)(3,30) in cycles 3..6, DONE in 7
    check("idle_busy", BUSY, 1'b0);
    do_cmd(15'd100, 15'd200, 4, 1'b1, t0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge CLK);
      check("basic_busy", BUSY, c <= 6);
      check("basic_done", DONE, c == 7);
    end
    @(negedge CLK);
    check("basic_done_pulse", DONE, 1'b0);
    #1;
    check("basic_drained", exp_q.size(), 0);

    // LEN=0: DONE one cycle after START, no SRAM access
    do_cmd(15'd5, 15'd5, 0, 1'b1, t0);
    @(negedge CLK);
    check("len0_done", DONE, 1'b1);
    check("len0_busy", BUSY, 1'b0);
    @(negedge CLK);
    check("len0_done_pulse", DONE, 1'b0);

    // START while busy is ignored
    do_cmd(15'd300, 15'd400, 3, 1'b1, t0);
    @(posedge CLK); #1;
    START = 1'b1;
    ROW_BASE = 15'd700;
    VEC_BASE = 15'd800;
    LEN = 16'd5;
    @(posedge CLK); #1;
    START = 1'b0;
    run_until_done(1'b0, d);
    check("ignore_done_cycle", d, t0 + 6);
    #1;
    check("ignore_drained", exp_q.size() + addr_q.size(), 0);

    // back-to-back: new START the cycle after DONE
    do_cmd(15'd1200, 15'd1300, 2, 1'b1, t0);
    check("b2b_start_cycle", t0, d + 1);
    run_until_done(1'b0, d);
    check("b2b_done_cycle", d, t0 + 5);

    // address wrap at 2^15
    do_cmd(15'd32766, 15'd1000, 4, 1'b1, t0);
    run_until_done(1'b0, d);
    check("wrap_done_cycle", d, t0 + 7);
    #1;
    check("wrap_drained", exp_q.size() + addr_q.size(), 0);

    // backpressure 1,0,0,1,0,1...
    do_cmd(15'd2000, 15'd3000, 6, 1'b0, t0);
    run_until_done(1'b1, d);
    #1;
    check("bp_drained", exp_q.size() + addr_q.size(), 0);

    // reset after 4 pairs of a LEN=10 command
    p0 = n_pop;
    do_cmd(15'd4000, 15'd5000, 10, 1'b1, t0);
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK); #1;
      if (n_pop >= p0 + 4) break;
    end
    check("midrst_pairs_before", n_pop - p0, 4);
    #1;
    RSTN = 1'b0;
    #1;
    check_reset_state("midrst");
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    check("midrst_no_done", DONE, 1'b0);
    RSTN = 1'b1;
    do_cmd(15'd6000, 15'd7000, 2, 1'b1, t0);
    run_until_done(1'b0, d);
    check("post_rst_done_cycle", d, t0 + 5);
    repeat (3) @(negedge CLK);
    #1;
    check("final_drained", exp_q.size() + addr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
